break_value_selector: RTL and testbench

- Downstream consumer of the break-value counter in the WalkSAT flip-selection path.
- Once a clause is chosen, it receives a stream of up to MAX_CANDIDATES (variable index, break value) pairs, one per literal of that clause.
- It picks the variable to flip: a zero-break freebie first, otherwise a noise-driven random candidate or the greedy minimum.
- It hands the result to the flip/assignment-update stage.

---
 rtl/sat_pkg.sv | 21 ++
 rtl/sat_lfsr.sv | 30 +++
 rtl/break_value_selector.sv | 163 ++++++++++++++++
 tb/tb_break_value_selector.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Definitions shared by the WalkSAT flip-selection stages: the selector state
// encoding, the LFSR polynomial and the candidate and noise limits.
package sat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          LFSR_WIDTH     = 16;
    // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam int          MAX_CAND_LIMIT = 8;
    localparam logic [7:0]  NOISE_ALWAYS   = 8'hFF;

    function automatic logic [3:0] clamp_count(input logic [3:0] req, input logic [3:0] limit);
        return (req > limit) ? limit : req;
    endfunction

endpackage

// File: rtl/sat_lfsr.sv
// Free-running Fibonacci LFSR. It advances on every clock out of reset and
// feeds the random decisions of the flip-selection stages.
module sat_lfsr
    import sat_pkg::*;
#(
    parameter int               WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] value_o
);

    localparam logic [WIDTH-1:0] TAPS = LFSR_TAPS[WIDTH-1:0];

    logic feedback;

    assign feedback = ^(value_o & TAPS);

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the values present before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_o <= SEED;
        end else begin
            value_o <= {value_o[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/break_value_selector.sv
// WalkSAT flip selection. It scans the (variable, break) pairs of the chosen
// clause and returns a zero-break freebie, a noise-driven random pick or the
// greedy minimum.
module break_value_selector
    import sat_pkg::*;
#(
    parameter int                    NUM_CLAUSES_BITS = 5,
    parameter int                    NUM_VARS_BITS    = 8,
    parameter int                    MAX_CANDIDATES   = 3,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED        = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_i,
    input  logic [3:0]                  num_cand_i,
    input  logic [7:0]                  noise_p_i,
    input  logic                        cand_valid_i,
    input  logic [NUM_VARS_BITS-1:0]    cand_var_i,
    input  logic [NUM_CLAUSES_BITS-1:0] cand_break_i,
    output logic                        cand_ready_o,
    output logic                        busy_o,
    output logic                        sel_valid_o,
    output logic [NUM_VARS_BITS-1:0]    sel_var_o,
    output logic [NUM_CLAUSES_BITS-1:0] sel_break_o,
    output logic                        sel_random_o,
    output logic                        sel_none_o
);

    localparam logic [3:0] CAND_CAP = 4'(MAX_CANDIDATES);

    state_e                      state, state_nxt;
    logic [LFSR_WIDTH-1:0]       lfsr;
    logic [3:0]                  clamped, num_cand, num_cand_nxt;
    logic [3:0]                  count, count_nxt, rand_idx, rand_idx_nxt;
    logic                        noise_hit, noise_hit_nxt, accept;
    logic [NUM_VARS_BITS-1:0]    min_var, min_var_nxt, rand_var, rand_var_nxt;
    logic [NUM_CLAUSES_BITS-1:0] min_break, min_break_nxt, rand_break, rand_break_nxt;
    logic                        load_result, none_nxt;
    logic [NUM_VARS_BITS-1:0]    sel_var_nxt;
    logic [NUM_CLAUSES_BITS-1:0] sel_break_nxt;
    logic                        sel_random_nxt;

    sat_lfsr #(
        .WIDTH(LFSR_WIDTH),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .value_o(lfsr)
    );

    assign clamped      = clamp_count(num_cand_i, CAND_CAP);
    assign cand_ready_o = (state == SCAN);
    assign busy_o       = (state != IDLE);
    assign sel_valid_o  = (state == DONE);
    assign accept       = cand_valid_i & cand_ready_o;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        num_cand_nxt   = num_cand;
        count_nxt      = count;
        rand_idx_nxt   = rand_idx;
        noise_hit_nxt  = noise_hit;
        min_var_nxt    = min_var;
        min_break_nxt  = min_break;
        rand_var_nxt   = rand_var;
        rand_break_nxt = rand_break;
        load_result    = 1'b0;
        none_nxt       = 1'b0;

        unique case (state)
            IDLE: begin
                if (start_i) begin
                    num_cand_nxt  = clamped;
                    // lfsr < {p, 8'h00} is the same test as lfsr[15:8] < p
                    noise_hit_nxt = (noise_p_i == NOISE_ALWAYS) || (lfsr < {noise_p_i, 8'h00});
                    rand_idx_nxt  = (clamped == 4'd0) ? 4'd0 : (lfsr[3:0] % clamped);
                    count_nxt     = 4'd0;
                    min_var_nxt   = '0;
                    min_break_nxt = '1;
                    if (clamped == 4'd0) begin
                        state_nxt   = DONE;
                        load_result = 1'b1;
                        none_nxt    = 1'b1;
                    end else begin
                        state_nxt = SCAN;
                    end
                end
            end
            SCAN: begin
                if (accept) begin
                    if (cand_break_i < min_break) begin
                        min_var_nxt   = cand_var_i;
                        min_break_nxt = cand_break_i;
                    end
                    if (count == rand_idx) begin
                        rand_var_nxt   = cand_var_i;
                        rand_break_nxt = cand_break_i;
                    end
                    count_nxt = count + 4'd1;
                    if (count_nxt == num_cand) begin
                        state_nxt   = DONE;
                        load_result = 1'b1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The result is built from the post-accept values so the final candidate counts.
    always_comb begin
        sel_var_nxt    = min_var_nxt;
        sel_break_nxt  = min_break_nxt;
        sel_random_nxt = 1'b0;
        if (none_nxt) begin
            sel_var_nxt   = '0;
            sel_break_nxt = '0;
        end else if ((min_break_nxt != '0) && noise_hit_nxt) begin
            sel_var_nxt    = rand_var_nxt;
            sel_break_nxt  = rand_break_nxt;
            sel_random_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            num_cand     <= '0;
            count        <= '0;
            rand_idx     <= '0;
            noise_hit    <= 1'b0;
            min_var      <= '0;
            min_break    <= '0;
            rand_var     <= '0;
            rand_break   <= '0;
            sel_var_o    <= '0;
            sel_break_o  <= '0;
            sel_random_o <= 1'b0;
            sel_none_o   <= 1'b0;
        end else begin
            state      <= state_nxt;
            num_cand   <= num_cand_nxt;
            count      <= count_nxt;
            rand_idx   <= rand_idx_nxt;
            noise_hit  <= noise_hit_nxt;
            min_var    <= min_var_nxt;
            min_break  <= min_break_nxt;
            rand_var   <= rand_var_nxt;
            rand_break <= rand_break_nxt;
            if (load_result) begin
                sel_var_o    <= sel_var_nxt;
                sel_break_o  <= sel_break_nxt;
                sel_random_o <= sel_random_nxt;
                sel_none_o   <= none_nxt;
            end
        end
    end

endmodule

// File: tb/tb_break_value_selector.sv
// Self-checking bench for break_value_selector: directed clause scans plus
// randomized runs against a behavioural model of the selection rules.
module tb_break_value_selector;

    localparam int          MAXC = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic [3:0] num_cand_i;
    logic [7:0] noise_p_i;
    logic       cand_valid_i;
    logic [7:0] cand_var_i;
    logic [4:0] cand_break_i;
    logic       cand_ready_o, busy_o, sel_valid_o, sel_random_o, sel_none_o;
    logic [7:0] sel_var_o;
    logic [4:0] sel_break_o;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [15:0] m_lfsr;
    logic [7:0]  cv[8];
    logic [4:0]  cb[8];

    break_value_selector #(
        .NUM_CLAUSES_BITS(5),
        .NUM_VARS_BITS   (8),
        .MAX_CANDIDATES  (MAXC),
        .LFSR_SEED       (SEED)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start_i     (start_i),
        .num_cand_i  (num_cand_i),
        .noise_p_i   (noise_p_i),
        .cand_valid_i(cand_valid_i),
        .cand_var_i  (cand_var_i),
        .cand_break_i(cand_break_i),
        .cand_ready_o(cand_ready_o),
        .busy_o      (busy_o),
        .sel_valid_o (sel_valid_o),
        .sel_var_o   (sel_var_o),
        .sel_break_o (sel_break_o),
        .sel_random_o(sel_random_o),
        .sel_none_o  (sel_none_o)
    );

    always #5 clk = ~clk;

    // Reference LFSR: polynomial x^16+x^14+x^13+x^11+1, one step per clock.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        int exps[4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (exps[k]) fb ^= v[exps[k]-1];
        return {v[14:0], fb};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    always @(negedge clk) begin
        if (rst_n && sel_valid_o) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set3(input logic [7:0] v0, input logic [4:0] b0, input logic [7:0] v1,
                        input logic [4:0] b1, input logic [7:0] v2, input logic [4:0] b2);
        cv[0] = v0; cb[0] = b0;
        cv[1] = v1; cb[1] = b1;
        cv[2] = v2; cb[2] = b2;
    endtask

    // gap < 0 selects random idle gaps of 0..2 cycles before each candidate.
    task automatic run_sel(input int ni, input logic [7:0] p, input int gap, input bit poke,
                           input string tag);
        int          n = (ni > MAXC) ? MAXC : ni;
        int          base, mi, gaps;
        logic [15:0] snap;
        logic [7:0]  e_var;
        logic [4:0]  e_break;
        logic        e_rand;

        @(negedge clk);
        start_i    = 1'b1;
        num_cand_i = 4'(ni);
        noise_p_i  = p;
        snap       = m_lfsr;
        base       = pulses;
        @(negedge clk);
        start_i    = 1'b0;
        num_cand_i = 4'(ni + 1);
        for (int i = 0; i < n; i++) begin
            gaps = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
            repeat (gaps) begin
                cand_valid_i = 1'b0;
                cand_var_i   = 8'($urandom);
                check({tag, " ready_gap"}, cand_ready_o, 1'b1);
                @(negedge clk);
            end
            check({tag, " ready"}, cand_ready_o, 1'b1);
            check({tag, " early_valid"}, sel_valid_o, 1'b0);
            if (poke && i == 0) begin
                start_i    = 1'b1;
                num_cand_i = 4'd0;
            end
            cand_valid_i = 1'b1;
            cand_var_i   = cv[i];
            cand_break_i = cb[i];
            @(negedge clk);
            cand_valid_i = 1'b0;
            start_i      = 1'b0;
        end

        e_rand = 1'b0;
        if (n == 0) begin
            e_var   = '0;
            e_break = '0;
        end else begin
            mi = 0;
            for (int i = 1; i < n; i++) if (cb[i] < cb[mi]) mi = i;
            e_var   = cv[mi];
            e_break = cb[mi];
            if (cb[mi] != 0 && (p == 8'hFF || snap[15:8] < p)) begin
                e_var   = cv[snap[3:0] % n];
                e_break = cb[snap[3:0] % n];
                e_rand  = 1'b1;
            end
        end

        check({tag, " sel_valid"}, sel_valid_o, 1'b1);
        check({tag, " busy_done"}, busy_o, 1'b1);
        check({tag, " ready_done"}, cand_ready_o, 1'b0);
        check({tag, " sel_var"}, sel_var_o, e_var);
        check({tag, " sel_break"}, sel_break_o, e_break);
        check({tag, " sel_random"}, sel_random_o, e_rand);
        check({tag, " sel_none"}, sel_none_o, (n == 0));
        @(negedge clk);
        check({tag, " valid_drop"}, sel_valid_o, 1'b0);
        check({tag, " idle"}, busy_o, 1'b0);
        check({tag, " held_var"}, sel_var_o, e_var);
        check({tag, " pulse_count"}, pulses, base + 1);
    endtask

    initial begin
        rst_n        = 1'b0;
        start_i      = 1'b0;
        num_cand_i   = '0;
        noise_p_i    = '0;
        cand_valid_i = 1'b0;
        cand_var_i   = '0;
        cand_break_i = '0;
        #1;
        check("rst ready", cand_ready_o, 1'b0);
        check("rst busy", busy_o, 1'b0);
        check("rst valid", sel_valid_o, 1'b0);
        check("rst var", sel_var_o, 8'd0);
        check("rst break", sel_break_o, 5'd0);
        check("rst flags", {sel_random_o, sel_none_o}, 2'b00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        set3(8'd10, 5'd4, 8'd11, 5'd2, 8'd12, 5'd7);
        run_sel(3, 8'h00, 0, 1'b0, "greedy");
        check("greedy direct_var", sel_var_o, 8'd11);

        set3(8'd20, 5'd3, 8'd21, 5'd3, 8'd22, 5'd5);
        run_sel(3, 8'h00, 2, 1'b0, "tie_gaps");
        check("tie_gaps direct_var", sel_var_o, 8'd20);

        set3(8'd30, 5'd5, 8'd31, 5'd0, 8'd32, 5'd2);
        run_sel(3, 8'hFF, 0, 1'b0, "freebie");
        check("freebie direct", {sel_var_o, sel_random_o}, {8'd31, 1'b0});

        set3(8'd40, 5'd3, 8'd41, 5'd4, 8'd42, 5'd6);
        for (int r = 0; r < 50; r++) run_sel(3, 8'hFF, 0, 1'b0, "random_walk");

        run_sel(0, 8'($urandom), 0, 1'b0, "none");
        set3(8'd50, 5'd6, 8'd51, 5'd1, 8'd52, 5'd9);
        run_sel(3, 8'h00, 1, 1'b1, "start_ignored");

        set3(8'd60, 5'd8, 8'd61, 5'd7, 8'd62, 5'd3);
        run_sel(9, 8'h00, 0, 1'b0, "clamp");

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < MAXC; i++) begin
                cv[i] = 8'($urandom);
                cb[i] = 5'($urandom_range(30, 0));
            end
            case ($urandom_range(2, 0))
                0:       run_sel(int'($urandom_range(4, 0)), 8'h00, -1, 1'b0, "rand");
                1:       run_sel(int'($urandom_range(4, 0)), 8'hFF, -1, 1'b0, "rand");
                default: run_sel(int'($urandom_range(4, 0)), 8'($urandom), -1, 1'b0, "rand");
            endcase
        end

        set3(8'd10, 5'd4, 8'd11, 5'd2, 8'd12, 5'd7);
        run_sel(3, 8'h00, 0, 1'b0, "pre_reset");
        begin
            int base;
            @(negedge clk);
            start_i    = 1'b1;
            num_cand_i = 4'd3;
            noise_p_i  = 8'h00;
            base       = pulses;
            @(negedge clk);
            start_i      = 1'b0;
            cand_valid_i = 1'b1;
            cand_var_i   = 8'd10;
            cand_break_i = 5'd4;
            @(negedge clk);
            cand_valid_i = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            check("midreset ready", cand_ready_o, 1'b0);
            check("midreset busy", busy_o, 1'b0);
            check("midreset valid", sel_valid_o, 1'b0);
            check("midreset var", sel_var_o, 8'd0);
            check("midreset break", sel_break_o, 5'd0);
            repeat (3) @(negedge clk);
            check("midreset no_pulse", pulses, base);
            rst_n = 1'b1;
        end
        run_sel(3, 8'h00, 0, 1'b0, "after_reset");
        check("after_reset direct_var", sel_var_o, 8'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
